// File: rtl/wb_stage_writer.sv
// MEM/WB pipeline register and register-file write-back source: one write pulse per retiring instruction.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
//
//  state     | meaning
//  IDLE      | ready for a new MEM-stage instruction; non-loads retire with latency 1
//  WAIT_LOAD | load captured, MEM stage stalled until dmem_rvalid
module wb_stage_writer #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [4:0]        in_rd_id,
  input  logic [1:0]        in_wb_sel,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [ADDR_W-1:0] in_pc_plus4,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              RegWrite,
  output logic [4:0]        rd_id,
  output logic [DATA_W-1:0] WBdata
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_cnt
`endif
);

  typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

  state_t            state, state_nxt;
  logic              ld_reg_write;
  logic [4:0]        ld_rd;
  logic [2:0]        ld_funct3;
  logic [2:0]        ld_off;
  logic              load_accept;
  logic [2:0]        off_al;
  logic [5:0]        shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;
  logic              reg_write_nxt;
  logic [4:0]        rd_id_nxt;
  logic [DATA_W-1:0] wb_data_nxt;

  assign in_ready    = (state == IDLE);
  assign load_accept = in_ready && in_valid && (in_wb_sel == 2'b01);

  // Offset bits below the access size are dropped so the shift lands on a naturally aligned lane.
  always_comb begin
    off_al = 3'b000;
    case (ld_funct3[1:0])
      2'b00:   off_al = ld_off;
      2'b01:   off_al = {ld_off[2:1], 1'b0};
      2'b10:   off_al = {ld_off[2], 2'b00};
      default: off_al = 3'b000;
    endcase
  end

  assign shamt   = {off_al, 3'b000};
  assign shifted = dmem_rdata >> shamt;

  always_comb begin
    load_ext = shifted;
    case (ld_funct3)
      3'b000:  load_ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
      3'b100:  load_ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      3'b110:  load_ext = {{(DATA_W-32){1'b0}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    reg_write_nxt = 1'b0;
    rd_id_nxt     = rd_id;
    wb_data_nxt   = WBdata;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_wb_sel == 2'b01) begin
            state_nxt = WAIT_LOAD;
          end else begin
            reg_write_nxt = in_reg_write && (in_rd_id != 5'd0);
            rd_id_nxt     = in_rd_id;
            wb_data_nxt   = (in_wb_sel == 2'b10) ? DATA_W'(in_pc_plus4) : in_alu_result;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_nxt     = IDLE;
          reg_write_nxt = ld_reg_write && (ld_rd != 5'd0);
          rd_id_nxt     = ld_rd;
          wb_data_nxt   = load_ext;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      RegWrite <= 1'b0;
      rd_id    <= 5'd0;
      WBdata   <= '0;
    end else begin
      state    <= state_nxt;
      RegWrite <= reg_write_nxt;
      rd_id    <= rd_id_nxt;
      WBdata   <= wb_data_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_reg_write <= 1'b0;
      ld_rd        <= 5'd0;
      ld_funct3    <= 3'd0;
      ld_off       <= 3'd0;
    end else if (load_accept) begin
      ld_reg_write <= in_reg_write;
      ld_rd        <= in_rd_id;
      ld_funct3    <= in_funct3;
      ld_off       <= in_alu_result[2:0];
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic retire_evt;

  assign retire_evt = (in_ready && in_valid && (in_wb_sel != 2'b01)) ||
                      ((state == WAIT_LOAD) && dmem_rvalid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_cnt <= 64'd0;
    else if (retire_evt) retire_cnt <= retire_cnt + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage_writer.sv
// Directed bench for wb_stage_writer: expected register-file writes go through a scoreboard queue.
// Covers retire_cnt as well when WB_RETIRE_CNT_EN is defined.
module tb_wb_stage_writer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd_id;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [63:0] in_alu_result;
  logic [63:0] in_pc_plus4;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        RegWrite;
  logic [4:0]  rd_id;
  logic [63:0] WBdata;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  wb_stage_writer #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg_write (in_reg_write),
    .in_rd_id     (in_rd_id),
    .in_wb_sel    (in_wb_sel),
    .in_funct3    (in_funct3),
    .in_alu_result(in_alu_result),
    .in_pc_plus4  (in_pc_plus4),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .RegWrite     (RegWrite),
    .rd_id        (rd_id),
    .WBdata       (WBdata)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt   (retire_cnt)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  wr_t        sb_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [4:0] pend_rd;
  logic       pend_rw;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    wr_t e;
    if (RegWrite === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 64'(RegWrite), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_rd_id", 64'(rd_id), 64'(e.rd));
        chk("sb_wbdata", WBdata, e.data);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    mon();
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    dmem_rvalid = 1'b0;
    cycle();
  endtask

  task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] pc);
    chk("accept_ready", 64'(in_ready), 64'd1);
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_rd_id      = rd;
    in_wb_sel     = sel;
    in_funct3     = f3;
    in_alu_result = alu;
    in_pc_plus4   = pc;
    if (sel == 2'b01) begin
      pend_rd = rd;
      pend_rw = rw;
    end else if (rw && rd != 5'd0) begin
      sb_q.push_back('{rd, (sel == 2'b10) ? pc : alu});
    end
    cycle();
  endtask

  task automatic respond(input logic [63:0] rdata, input logic [63:0] exp);
    in_valid    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    if (pend_rw && pend_rd != 5'd0) sb_q.push_back('{pend_rd, exp});
    cycle();
    dmem_rvalid = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off,
                      input logic [63:0] rdata, input logic [63:0] exp, input string tag);
    send(1'b1, rd, 2'b01, f3, {61'h100, off}, 64'd0);
    in_valid = 1'b0;
    chk({tag, "_stall"}, 64'(in_ready), 64'd0);
    respond(rdata, exp);
    chk({tag, "_regwrite"}, 64'(RegWrite), 64'd1);
    chk({tag, "_data"}, WBdata, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_reg_write = 1'b0; in_rd_id = 5'd0; in_wb_sel = 2'b00;
    in_funct3 = 3'd0; in_alu_result = 64'd0; in_pc_plus4 = 64'd0;
    dmem_rvalid = 1'b0; dmem_rdata = 64'd0; pend_rd = 5'd0; pend_rw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_rd_id", 64'(rd_id), 64'd0);
    chk("rst_wbdata", WBdata, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire_cnt", retire_cnt, 64'd0);
`endif

    // ALU write, then hold on the following idle cycle
    send(1'b1, 5'd5, 2'b00, 3'd0, 64'h1234, 64'h0);
    chk("alu_regwrite", 64'(RegWrite), 64'd1);
    chk("alu_rd_id", 64'(rd_id), 64'd5);
    chk("alu_wbdata", WBdata, 64'h1234);
    idle();
    chk("alu_pulse_end", 64'(RegWrite), 64'd0);
    chk("hold_rd_id", 64'(rd_id), 64'd5);
    chk("hold_wbdata", WBdata, 64'h1234);

    // LB with a response present in the accepting cycle (must be ignored) and two idle wait cycles
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    send(1'b1, 5'd7, 2'b01, 3'b000, 64'h2003, 64'h0);
    in_valid = 1'b0; dmem_rvalid = 1'b0;
    chk("lb_ignore_rvalid_ready", 64'(in_ready), 64'd0);
    chk("lb_ignore_rvalid_we", 64'(RegWrite), 64'd0);
    idle();
    chk("lb_wait1_ready", 64'(in_ready), 64'd0);
    chk("lb_wait1_we", 64'(RegWrite), 64'd0);
    idle();
    chk("lb_wait2_ready", 64'(in_ready), 64'd0);
    respond(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_regwrite", 64'(RegWrite), 64'd1);
    chk("lb_ready_back", 64'(in_ready), 64'd1);
    idle();
    chk("lb_pulse_end", 64'(RegWrite), 64'd0);

    load(5'd8,  3'b110, 3'd4, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, "lwu");
    load(5'd9,  3'b101, 3'd5, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_0000_BEEF, "lhu");
    load(5'd10, 3'b001, 3'd7, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, "lh");
    load(5'd11, 3'b010, 3'd3, 64'h0000_0000_8765_4321, 64'hFFFF_FFFF_8765_4321, "lw");
    load(5'd12, 3'b111, 3'd5, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, "f3_111");
    load(5'd13, 3'b011, 3'd6, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, "ld");
    load(5'd14, 3'b100, 3'd7, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB, "lbu");

    // Stray response while idle changes nothing
    in_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'h5555_5555_5555_5555;
    cycle();
    dmem_rvalid = 1'b0;
    chk("idle_rvalid_we", 64'(RegWrite), 64'd0);
    chk("idle_rvalid_ready", 64'(in_ready), 64'd1);
    chk("idle_rvalid_hold", WBdata, 64'h0000_0000_0000_00AB);

    // Back-to-back ALU / JAL / ALU to x0
    send(1'b1, 5'd1, 2'b00, 3'd0, 64'hCAFE_0001, 64'h0);
    chk("b2b0_we", 64'(RegWrite), 64'd1);
    send(1'b1, 5'd2, 2'b10, 3'd0, 64'h9999, 64'h1004);
    chk("b2b1_we", 64'(RegWrite), 64'd1);
    chk("b2b1_wbdata", WBdata, 64'h1004);
    send(1'b1, 5'd0, 2'b11, 3'd0, 64'h77, 64'h0);
    chk("b2b2_x0_we", 64'(RegWrite), 64'd0);
    chk("b2b2_ready", 64'(in_ready), 64'd1);
    send(1'b0, 5'd3, 2'b11, 3'd0, 64'h88, 64'h0);
    chk("no_regwrite_we", 64'(RegWrite), 64'd0);
    idle();

    // Reset asserted mid-load
    send(1'b1, 5'd15, 2'b01, 3'b011, 64'h0, 64'h0);
    in_valid = 1'b0;
    chk("midload_stall", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("midrst_regwrite", 64'(RegWrite), 64'd0);
    chk("midrst_rd_id", 64'(rd_id), 64'd0);
    chk("midrst_wbdata", WBdata, 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 64'h1111_2222_3333_4444;
    cycle();
    dmem_rvalid = 1'b0;
    chk("postrst_rvalid_we", 64'(RegWrite), 64'd0);
    chk("postrst_rvalid_data", WBdata, 64'd0);
    chk("postrst_ready", 64'(in_ready), 64'd1);

    // Three ALU retires and two loads, one of them to x0
    send(1'b1, 5'd20, 2'b00, 3'd0, 64'hA, 64'h0);
    send(1'b1, 5'd21, 2'b11, 3'd0, 64'hB, 64'h0);
    send(1'b1, 5'd22, 2'b10, 3'd0, 64'h0, 64'h2008);
    load(5'd23, 3'b000, 3'd0, 64'h7F, 64'h7F, "lb_pos");
    send(1'b1, 5'd0, 2'b01, 3'b011, 64'h0, 64'h0);
    in_valid = 1'b0;
    respond(64'h1234, 64'h1234);
    chk("ld_x0_we", 64'(RegWrite), 64'd0);
    idle();
`ifdef WB_RETIRE_CNT_EN
    chk("retire_cnt_5", retire_cnt, 64'd5);
    force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt;
    send(1'b0, 5'd0, 2'b00, 3'd0, 64'h0, 64'h0);
    in_valid = 1'b0;
    chk("retire_cnt_wrap", retire_cnt, 64'd0);
    idle();
`endif

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
